// File: rtl/data_mem_arbiter.sv
// Shares the single-port data block memory between the core load/store path (fixed priority)
// and a host port, with a saturating wait counter that forces a host grant after HOST_MAX_WAIT losses.
module data_mem_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 16,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        H_DATA = 2'd1,
        H_ACK  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        wait_cnt_r;
    logic              host_rd_r;
    logic              host_ack_r;
    logic [DATA_W-1:0] host_rdata_r;
    logic              host_grant_s;
    logic              core_grant_s;
    logic              mem_we_s;

    // Grant decision; nothing is granted while reset is held so every output sits at its reset value.
    always_comb begin
        host_grant_s = 1'b0;
        core_grant_s = 1'b0;
        if (reset) begin
            host_grant_s = 1'b0;
            core_grant_s = 1'b0;
        end else begin
            host_grant_s = (state_r == IDLE) && host_req && (!core_req || (wait_cnt_r == MAX_WAIT));
            core_grant_s = core_req && !host_grant_s;
        end
    end

    // Memory port mux: the granted side drives the port, otherwise it is parked at zero.
    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we_s = 1'b0;
        if (host_grant_s) begin
            mem_addr = host_addr;
            mem_din  = host_wdata;
            mem_we_s = host_we;
        end else if (core_grant_s) begin
            mem_addr = core_addr;
            mem_din  = core_wdata;
            mem_we_s = core_we;
        end else begin
            mem_addr = '0;
            mem_din  = '0;
            mem_we_s = 1'b0;
        end
    end

    assign mem_we     = mem_we_s & ~reset;
    assign core_stall = core_req & host_grant_s;
    assign core_rdata = mem_dout;
    assign host_ack   = host_ack_r;
    assign host_rdata = host_rdata_r;

    // Host transaction sequencing: grant, data return, acknowledge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (host_grant_s) begin
                    state_s = H_DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            H_DATA:  state_s = H_ACK;
            H_ACK:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; reset drops any in-flight host transaction.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counts contended cycles the host has lost, saturating at the forced-grant threshold.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (host_grant_s) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == IDLE) && host_req && (wait_cnt_r != MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Host response path: remember read/write at grant, capture read data, pulse ack.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            host_rd_r    <= 1'b0;
            host_ack_r   <= 1'b0;
            host_rdata_r <= '0;
        end else begin
            host_ack_r <= (state_r == H_DATA);
            if (host_grant_s) begin
                host_rd_r <= !host_we;
            end
            if ((state_r == H_DATA) && host_rd_r) begin
                host_rdata_r <= mem_dout;
            end
        end
    end

endmodule
